// File: rtl/sync_fifo_pkg.sv
// Shared defaults and elaboration helpers for the parametrised synchronous FIFO.
// Imported by the FIFO top and its storage array.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_DEPTH      = 8;

    // Ceiling log2; the result for a value of 1 or less is 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array with one synchronous write port and one
// asynchronous read port. The contents are not reset.
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEFAULT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost thresholds, sticky
// error flags, synchronous flush and an optional first-word-fall-through read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  DEPTH      = DEFAULT_DEPTH,
    parameter int  AF_THRESH  = DEPTH - 1,
    parameter int  AE_THRESH  = 1,
    parameter int  FWFT       = 0,
    localparam int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_vld,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end

    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_LEVEL   = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0]   AE_LEVEL   = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic                  empty_reg, empty_next;
    logic                  full_reg, full_next;
    logic                  af_reg, af_next;
    logic                  ae_reg, ae_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;

    logic                  rd_acc, wr_acc;
    logic                  rd_take, wr_take;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // A read frees a slot on the same edge, so a full FIFO still takes a write.
    assign rd_acc  = rd_en & ~empty_reg;
    assign wr_acc  = wr_en & (~full_reg | rd_acc);
    assign rd_take = rd_acc & ~flush;
    assign wr_take = wr_acc & ~flush;

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg & ~err_clr;
        underflow_next = underflow_reg & ~err_clr;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_take) begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
            end
            if (rd_take) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            case ({wr_take, rd_take})
                2'b10:   count_next = count_reg + COUNT_ONE;
                2'b01:   count_next = count_reg - COUNT_ONE;
                default: count_next = count_reg;
            endcase
            // Setting an error flag wins over a simultaneous err_clr.
            if (wr_en & full_reg & ~rd_acc) begin
                overflow_next = 1'b1;
            end
            if (rd_en & empty_reg) begin
                underflow_next = 1'b1;
            end
        end

        // On flush count_next is 0, which yields exactly the reset flag values.
        empty_next = (count_next == '0);
        full_next  = (count_next == FULL_LEVEL);
        af_next    = (count_next >= AF_LEVEL);
        ae_next    = (count_next <= AE_LEVEL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            empty_reg     <= empty_next;
            full_reg      <= full_next;
            af_reg        <= af_next;
            ae_reg        <= ae_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_take),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_in),
        .rd_addr (rd_ptr_reg),
        .rd_data (mem_rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is presented directly; forced to 0 while empty so reset shows 0.
        assign data_out = empty_reg ? '0 : mem_rd_data;
        assign rd_vld   = ~empty_reg;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] data_out_reg;
        logic                  rd_vld_reg;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                data_out_reg <= '0;
                rd_vld_reg   <= 1'b0;
            end else begin
                rd_vld_reg <= rd_take;
                if (rd_take) begin
                    data_out_reg <= mem_rd_data;
                end
            end
        end

        assign data_out = data_out_reg;
        assign rd_vld   = rd_vld_reg;
    end

    assign fifo_empty   = empty_reg;
    assign fifo_full    = full_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;
    assign fifo_count   = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one FWFT instance, each
// checked every cycle against a queue-based model of the FIFO rules.
module tb_sync_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rstn;

    logic          flush0, wr0, rd0, ec0;
    logic [DW-1:0] din0, dout0;
    logic          vld0, emp0, full0, af0, ae0, ovf0, udf0;
    logic [AW:0]   cnt0;

    logic          flush1, wr1, rd1, ec1;
    logic [DW-1:0] din1, dout1;
    logic          vld1, emp1, full1, af1, ae1, ovf1, udf1;
    logic [AW:0]   cnt1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] m_dout0;
    logic          m_vld0, m_ovf0, m_udf0;
    logic [DW-1:0] q1[$];
    logic          m_ovf1, m_udf1;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut0 (
        .clk(clk), .rstn(rstn), .flush(flush0), .wr_en(wr0), .data_in(din0),
        .rd_en(rd0), .data_out(dout0), .rd_vld(vld0), .fifo_empty(emp0),
        .fifo_full(full0), .almost_full(af0), .almost_empty(ae0),
        .fifo_count(cnt0), .overflow(ovf0), .underflow(udf0), .err_clr(ec0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut1 (
        .clk(clk), .rstn(rstn), .flush(flush1), .wr_en(wr1), .data_in(din1),
        .rd_en(rd1), .data_out(dout1), .rd_vld(vld1), .fifo_empty(emp1),
        .fifo_full(full1), .almost_full(af1), .almost_empty(ae1),
        .fifo_count(cnt1), .overflow(ovf1), .underflow(udf1), .err_clr(ec1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_dout0 = '0;
        m_vld0  = 1'b0;
        m_ovf0  = 1'b0;
        m_udf0  = 1'b0;
        m_ovf1  = 1'b0;
        m_udf1  = 1'b0;
    endtask

    task automatic check0(input string tag);
        int sz;
        sz = q0.size();
        check({tag, " data_out"}, dout0, m_dout0);
        check({tag, " rd_vld"}, vld0, m_vld0);
        check({tag, " empty"}, emp0, sz == 0);
        check({tag, " full"}, full0, sz == DEPTH);
        check({tag, " almost_full"}, af0, sz >= DEPTH - 1);
        check({tag, " almost_empty"}, ae0, sz <= 1);
        check({tag, " count"}, cnt0, sz);
        check({tag, " overflow"}, ovf0, m_ovf0);
        check({tag, " underflow"}, udf0, m_udf0);
    endtask

    task automatic check1(input string tag);
        int sz;
        sz = q1.size();
        check({tag, " data_out"}, dout1, (sz > 0) ? q1[0] : 8'h00);
        check({tag, " rd_vld"}, vld1, sz > 0);
        check({tag, " empty"}, emp1, sz == 0);
        check({tag, " full"}, full1, sz == DEPTH);
        check({tag, " almost_full"}, af1, sz >= DEPTH - 1);
        check({tag, " almost_empty"}, ae1, sz <= 1);
        check({tag, " count"}, cnt1, sz);
        check({tag, " overflow"}, ovf1, m_ovf1);
        check({tag, " underflow"}, udf1, m_udf1);
    endtask

    // One clock of the registered-read instance, then model update and compare.
    task automatic cycle0(input logic w, input logic [DW-1:0] d, input logic r,
                          input logic f, input logic ec);
        int  pre;
        bit  racc, wacc, so, su;
        wr0 = w; din0 = d; rd0 = r; flush0 = f; ec0 = ec;
        @(posedge clk);
        #1;
        pre = q0.size();
        so = 0; su = 0;
        if (f) begin
            q0.delete();
            m_vld0 = 1'b0;
        end else begin
            racc = r && (pre > 0);
            wacc = w && ((pre < DEPTH) || racc);
            so   = w && (pre == DEPTH) && !racc;
            su   = r && (pre == 0);
            m_vld0 = racc;
            if (racc) m_dout0 = q0.pop_front();
            if (wacc) q0.push_back(d);
        end
        m_ovf0 = so || (m_ovf0 && !ec);
        m_udf0 = su || (m_udf0 && !ec);
        cyc++;
        check0($sformatf("reg c%0d", cyc));
        wr0 = 0; rd0 = 0; flush0 = 0; ec0 = 0;
    endtask

    task automatic cycle1(input logic w, input logic [DW-1:0] d, input logic r,
                          input logic f, input logic ec);
        int  pre;
        bit  racc, wacc, so, su;
        wr1 = w; din1 = d; rd1 = r; flush1 = f; ec1 = ec;
        @(posedge clk);
        #1;
        pre = q1.size();
        so = 0; su = 0;
        if (f) begin
            q1.delete();
        end else begin
            racc = r && (pre > 0);
            wacc = w && ((pre < DEPTH) || racc);
            so   = w && (pre == DEPTH) && !racc;
            su   = r && (pre == 0);
            if (racc) void'(q1.pop_front());
            if (wacc) q1.push_back(d);
        end
        m_ovf1 = so || (m_ovf1 && !ec);
        m_udf1 = su || (m_udf1 && !ec);
        cyc++;
        check1($sformatf("fwft c%0d", cyc));
        wr1 = 0; rd1 = 0; flush1 = 0; ec1 = 0;
    endtask

    initial begin
        rstn = 1'b0;
        {flush0, wr0, rd0, ec0, din0} = '0;
        {flush1, wr1, rd1, ec1, din1} = '0;
        model_reset();
        #12;
        check0("reset");
        check1("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Fill to full, then drain in order.
        for (int i = 0; i < DEPTH; i++) cycle0(1, 8'(i), 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle0(0, 0, 1, 0, 0);
        cycle0(0, 0, 0, 0, 0);

        // Overflow on full, underflow on empty, then clear.
        for (int i = 0; i < DEPTH; i++) cycle0(1, 8'(i), 0, 0, 0);
        cycle0(1, 8'hAA, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle0(0, 0, 1, 0, 0);
        cycle0(0, 0, 1, 0, 0);
        cycle0(0, 0, 0, 0, 1);

        // Simultaneous write/read while full, then pointer wrap.
        for (int i = 0; i < DEPTH; i++) cycle0(1, 8'(i), 0, 0, 0);
        cycle0(1, 8'h55, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle0(0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle0(1, 8'($urandom), 0, 0, 0);
            cycle0(0, 0, 1, 0, 0);
        end

        // Flush discards contents and the same-cycle write.
        for (int i = 0; i < 5; i++) cycle0(1, 8'(8'h20 + i), 0, 0, 0);
        cycle0(1, 8'h11, 0, 1, 0);
        cycle0(0, 0, 1, 0, 0);
        cycle0(0, 0, 0, 0, 1);

        // Empty-FIFO write+read: write lands, read flags underflow.
        cycle0(1, 8'h77, 1, 0, 0);
        cycle0(0, 0, 1, 0, 1);

        // FWFT: written word appears without rd_en, one pop empties it.
        cycle1(1, 8'h3C, 0, 0, 0);
        cycle1(0, 0, 1, 0, 0);
        cycle1(0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) cycle1(1, 8'($urandom), 0, 0, 0);
        cycle1(1, 8'h99, 1, 0, 0);

        // Asynchronous reset between edges while a burst is in progress.
        for (int i = 0; i < 3; i++) cycle0(1, 8'(8'h40 + i), 0, 0, 0);
        wr0 = 1; din0 = 8'h43;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check0("async reset");
        check1("async reset");
        wr0 = 0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle0(1, 8'(8'h50 + i), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle0(0, 0, 1, 0, 0);

        // Randomised traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            cycle0(1'($urandom), 8'($urandom), 1'($urandom), ($urandom % 32) == 0,
                   ($urandom % 16) == 0);
        end
        for (int i = 0; i < 200; i++) begin
            cycle1(1'($urandom), 8'($urandom), 1'($urandom), ($urandom % 32) == 0,
                   ($urandom % 16) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
